// File: rtl/ibuff_top.sv
// Instruction buffer between fetch and D1: circular FIFO of {instr, pc, exception}
// with valid/ready on both sides. Optional same-cycle bypass when `IBUFF_BYPASS_EN is defined.
module ibuff_top #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [XLEN-1:0]          f_instr,
  input  logic [XLEN-1:0]          f_pc,
  input  logic                     f_exception,
  output logic                     d1_valid,
  input  logic                     d1_ready,
  output logic [XLEN-1:0]          IBuff_out,
  output logic [XLEN-1:0]          pc_out,
  output logic                     exception_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            exc_hold_q, exc_hold_d;
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic            exc_mem_q   [DEPTH];

  logic empty_s, full_s, push_s, pop_s, bypass_s, pass_s, wr_en_s, rd_adv_s;

  // Occupancy flags, handshakes and bypass qualification
  always_comb begin
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    f_ready = ~full_s & ~exc_hold_q & ~flush;
    push_s  = f_valid & f_ready;
`ifdef IBUFF_BYPASS_EN
    bypass_s = empty_s & push_s;
`else
    bypass_s = 1'b0;
`endif
    d1_valid = ~empty_s | bypass_s;
    pop_s    = d1_valid & d1_ready & ~flush;
    // A bypassed entry consumed in the same cycle never touches the array
    pass_s   = bypass_s & d1_ready;
    wr_en_s  = push_s & ~pass_s;
    rd_adv_s = pop_s & ~pass_s;
    count    = wr_ptr_q - rd_ptr_q;
  end

  // Head presentation: bypassed fetch, stored head, or zeros when idle
  always_comb begin
    IBuff_out     = {XLEN{1'b0}};
    pc_out        = {XLEN{1'b0}};
    exception_out = 1'b0;
    if (bypass_s) begin
      IBuff_out     = f_instr;
      pc_out        = f_pc;
      exception_out = f_exception;
    end else if (d1_valid) begin
      IBuff_out     = instr_mem_q[rd_ptr_q[AW-1:0]];
      pc_out        = pc_mem_q[rd_ptr_q[AW-1:0]];
      exception_out = exc_mem_q[rd_ptr_q[AW-1:0]];
    end else begin
      IBuff_out     = {XLEN{1'b0}};
      pc_out        = {XLEN{1'b0}};
      exception_out = 1'b0;
    end
  end

  // Pointer and exception-hold next state; flush discards everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    exc_hold_d = exc_hold_q;
    if (flush) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      exc_hold_d = 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_adv_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      exc_hold_d = exc_hold_q | (push_s & f_exception);
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      exc_hold_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      exc_hold_q <= exc_hold_d;
    end
  end

  // Entry storage; contents are don't-care until pointed at, so no reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      instr_mem_q[wr_ptr_q[AW-1:0]] <= f_instr;
      pc_mem_q[wr_ptr_q[AW-1:0]]    <= f_pc;
      exc_mem_q[wr_ptr_q[AW-1:0]]   <= f_exception;
    end
  end

endmodule

// File: tb/tb_ibuff_top.sv
// Scoreboard bench for ibuff_top: a queue-based reference model predicts handshakes,
// count and the order of entries delivered to D1.
module tb_ibuff_top;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IBUFF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk, rst, flush, f_valid, f_ready, f_exception;
  logic            d1_valid, d1_ready, exception_out;
  logic [XLEN-1:0] f_instr, f_pc, IBuff_out, pc_out;
  logic [CW-1:0]   count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } ent_t;

  ent_t exp_q[$];
  bit   hold_m;
  bit   last_push;
  int   n_chk;
  int   n_fail;

  ibuff_top #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
    .f_exception(f_exception),
    .d1_valid(d1_valid), .d1_ready(d1_ready),
    .IBuff_out(IBuff_out), .pc_out(pc_out), .exception_out(exception_out),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; handshake/occupancy checks and model update at negedge
  task automatic cyc(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                     input bit ex, input bit dr, input bit fl);
    bit fr_m;
    bit pv;
    @(posedge clk);
    #1;
    f_valid = fv; f_instr = ins; f_pc = pc; f_exception = ex;
    d1_ready = dr; flush = fl;
    @(negedge clk);
    fr_m = (exp_q.size() < DEPTH) && !hold_m && !fl;
    pv   = fv && fr_m;
    chk("f_ready", 65'(f_ready), 65'(fr_m));
    chk("count", 65'(count), 65'(exp_q.size()));
    chk("d1_valid", 65'(d1_valid), 65'((exp_q.size() != 0) || (BYP && pv)));
    if (!d1_valid) chk("masked_head", {IBuff_out, pc_out, exception_out}, 65'd0);
    last_push = pv;
    if (fl) begin
      exp_q.delete();
      hold_m = 1'b0;
    end else if (pv) begin
      exp_q.push_back('{instr: ins, pc: pc, exc: ex});
      if (ex) hold_m = 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("drain_done", 65'(exp_q.size()), 65'd0);
  endtask

  // Monitor: every D1 consumption is checked against the oldest expected entry
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !flush && d1_valid && d1_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got pc 0x%0h with nothing expected", pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("head", {IBuff_out, pc_out, exception_out}, e);
        end
      end
    end
  end

  initial begin
    int k;
    n_chk = 0; n_fail = 0; hold_m = 1'b0; last_push = 1'b0;
    rst = 1'b1; flush = 1'b0; f_valid = 1'b0; f_instr = 32'd0; f_pc = 32'd0;
    f_exception = 1'b0; d1_ready = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_d1_valid", 65'(d1_valid), 65'd0);
    chk("rst_f_ready", 65'(f_ready), 65'd1);
    chk("rst_count", 65'(count), 65'd0);
    chk("rst_head", {IBuff_out, pc_out, exception_out}, 65'd0);

    // Three entries queued, then drained in order
    cyc(1'b1, 32'hA, 32'h100, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 32'h104, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 32'h108, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 1'b0);
    chk("three_count", 65'(count), 65'd3);
    drain();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Fill, then keep fetch offering while D1 pops: ordering across wrap
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1000 + i, 32'h400 + 4 * i, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h2000, 32'h800, 1'b0, 1'b0, 1'b0);
    chk("full_count", 65'(count), 65'(DEPTH));
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h2000 + k, 32'h800 + 4 * k, 1'b0, 1'b1, 1'b0);
      if (last_push) k++;
    end
    drain();

    // Exception stops intake until flush
    cyc(1'b1, 32'hE, 32'h200, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hF, 32'h204, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hF, 32'h204, 1'b0, 1'b0, 1'b0);
    drain();
    cyc(1'b1, 32'hF, 32'h204, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 1'b0);

    // Flush with simultaneous push and pop
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h50 + i, 32'h500 + 4 * i, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h77, 32'h5F0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 1'b0);

`ifdef IBUFF_BYPASS_EN
    // Bypass straight through when empty
    cyc(1'b1, 32'h33, 32'h300, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b0);
`endif

    // Randomized traffic with occasional exceptions and flushes
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end
    drain();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
